// File: rtl/branch_predictor_param_pkg.sv
// branch_predictor_param_pkg: counter encodings, reset value and mode codes for the predictor
package branch_predictor_param_pkg;
`include "bp_defs.vh"
  typedef enum logic [1:0] {SNT = `BP_SNT, WNT = `BP_WNT, WT = `BP_WT, ST = `BP_ST} ctr_e;
  localparam logic [1:0] CTR_RST = `BP_CTR_RST;
  localparam int MODE_LOCAL = `BP_MODE_LOCAL;
  localparam int MODE_GSHARE = `BP_MODE_GSHARE;
endpackage

// File: rtl/bp_defs.vh
`ifndef BP_DEFS_VH
`define BP_DEFS_VH
`define BP_SNT 2'b00
`define BP_WNT 2'b01
`define BP_WT 2'b10
`define BP_ST 2'b11
`define BP_CTR_RST `BP_WNT
`define BP_MODE_LOCAL 0
`define BP_MODE_GSHARE 1
`endif

// File: rtl/sat2_update.sv
// sat2_update: 2-bit saturating counter step toward the resolved outcome
module sat2_update
  import branch_predictor_param_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] nxt
);
  assign nxt = taken ? ((ctr == ST) ? ST : ctr + 2'd1) : ((ctr == SNT) ? SNT : ctr - 2'd1);
endmodule

// File: rtl/branch_predictor_param.sv
// branch_predictor_param: gshare/local-history 2-bit predictor with registered D-stage lookup
module branch_predictor_param
  import branch_predictor_param_pkg::*;
#(
  parameter int PHT_LOG2 = 10,
  parameter int HIST_W   = 8,
  parameter int BHT_LOG2 = 6,
  parameter int MODE     = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         pcF,
  input  logic                stallD,
  input  logic                flushD,
  output logic                pred_takeD,
  output logic [PHT_LOG2-1:0] pred_idxD,
  input  logic                upd_valid,
  input  logic [31:0]         upd_pc,
  input  logic [PHT_LOG2-1:0] upd_idx,
  input  logic                upd_pred,
  input  logic                upd_taken,
  output logic                mispredict,
  output logic [31:0]         stat_lookups,
  output logic [31:0]         stat_mispred
);
  localparam int PHT_N = 1 << PHT_LOG2;
  localparam int BHT_N = 1 << BHT_LOG2;
  logic [1:0]          pht_q [PHT_N];
  logic [1:0]          pht_d [PHT_N];
  logic [HIST_W-1:0]   bht_q [BHT_N];
  logic [HIST_W-1:0]   bht_d [BHT_N];
  logic [HIST_W-1:0]   ghr_q, ghr_d, hist;
  logic [PHT_LOG2-1:0] idx, pred_idx_q, pred_idx_d;
  logic                pred_take_q, pred_take_d;
  logic [31:0]         stat_lookups_q, stat_lookups_d, stat_mispred_q, stat_mispred_d;
  logic [BHT_LOG2-1:0] bht_rd, bht_wr;
  logic [1:0]          ctr_nxt;
  logic                unused_bits;
  assign bht_rd = pcF[BHT_LOG2+1:2];
  assign bht_wr = upd_pc[BHT_LOG2+1:2];
  assign unused_bits = ^{pcF, upd_pc};
  assign mispredict = upd_valid & (upd_pred != upd_taken);
  sat2_update u_sat (.ctr(pht_q[upd_idx]), .taken(upd_taken), .nxt(ctr_nxt));
  // Lookup reads only _q state, so a same-cycle update is never bypassed into the prediction
  always_comb begin
    hist = (MODE == MODE_LOCAL) ? bht_q[bht_rd] : ghr_q;
    idx = pcF[PHT_LOG2+1:2] ^ PHT_LOG2'(hist);
    pred_take_d = flushD ? 1'b0 : stallD ? pred_take_q : pht_q[idx][1];
    pred_idx_d = flushD ? '0 : stallD ? pred_idx_q : idx;
    pht_d = pht_q;
    bht_d = bht_q;
    ghr_d = ghr_q;
    if (upd_valid) begin
      pht_d[upd_idx] = ctr_nxt;
      if (MODE == MODE_GSHARE) ghr_d = HIST_W'({ghr_q, upd_taken});
      else bht_d[bht_wr] = HIST_W'({bht_q[bht_wr], upd_taken});
    end
    stat_lookups_d = stat_lookups_q + 32'(!stallD && !flushD);
    stat_mispred_d = stat_mispred_q + 32'(mispredict);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PHT_N; i++) pht_q[i] <= CTR_RST;
      for (int i = 0; i < BHT_N; i++) bht_q[i] <= '0;
      ghr_q <= '0;
      pred_take_q <= 1'b0;
      pred_idx_q <= '0;
      stat_lookups_q <= '0;
      stat_mispred_q <= '0;
    end else begin
      pht_q <= pht_d;
      bht_q <= bht_d;
      ghr_q <= ghr_d;
      pred_take_q <= pred_take_d;
      pred_idx_q <= pred_idx_d;
      stat_lookups_q <= stat_lookups_d;
      stat_mispred_q <= stat_mispred_d;
    end
  end
  assign pred_takeD = pred_take_q;
  assign pred_idxD = pred_idx_q;
  assign stat_lookups = stat_lookups_q;
  assign stat_mispred = stat_mispred_q;
endmodule

// File: tb/tb_branch_predictor_param.sv
// tb_branch_predictor_param: scoreboard bench driving a gshare and a local-history instance in lockstep
module tb_branch_predictor_param;
  logic        clk = 0;
  logic        rst, stallD, flushD, upd_valid, upd_pred, upd_taken;
  logic [31:0] pcF, upd_pc;
  logic [9:0]  upd_idx;
  logic        g_take, l_take, g_mis, l_mis;
  logic [9:0]  g_idx, l_idx;
  logic [31:0] g_look, g_mp, l_look, l_mp;
  always #5 clk = ~clk;
  branch_predictor_param #(.MODE(1)) dut (
    .clk(clk), .rst(rst), .pcF(pcF), .stallD(stallD), .flushD(flushD),
    .pred_takeD(g_take), .pred_idxD(g_idx), .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_idx(upd_idx), .upd_pred(upd_pred), .upd_taken(upd_taken), .mispredict(g_mis),
    .stat_lookups(g_look), .stat_mispred(g_mp));
  branch_predictor_param #(.MODE(0)) dut_l (
    .clk(clk), .rst(rst), .pcF(pcF), .stallD(stallD), .flushD(flushD),
    .pred_takeD(l_take), .pred_idxD(l_idx), .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_idx(upd_idx), .upd_pred(upd_pred), .upd_taken(upd_taken), .mispredict(l_mis),
    .stat_lookups(l_look), .stat_mispred(l_mp));
  typedef struct {int due; int sig; logic [31:0] v; string nm;} exp_t;
  exp_t q[$];
  exp_t keep[$];
  int cyc = 0, n_chk = 0, n_fail = 0;
  logic [31:0] a;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [31:0] act(int s);
    case (s)
      0: return {31'd0, g_take};
      1: return {22'd0, g_idx};
      2: return {31'd0, g_mis};
      3: return g_look;
      4: return g_mp;
      5: return {31'd0, l_take};
      6: return {22'd0, l_idx};
      7: return l_look;
      default: return {31'd0, l_mis};
    endcase
  endfunction
  // Monitor: every negedge, compare all expectations due in this cycle
  always @(negedge clk) begin
    keep = {};
    foreach (q[i]) begin
      if (q[i].due == cyc) begin
        n_chk++;
        a = act(q[i].sig);
        if (a !== q[i].v) begin
          n_fail++;
          $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", q[i].nm, a, q[i].v, cyc);
        end
      end else keep.push_back(q[i]);
    end
    q = keep;
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(int off, int sig, logic [31:0] v, string nm);
    exp_t e;
    e.due = cyc + off; e.sig = sig; e.v = v; e.nm = nm;
    q.push_back(e);
  endtask
  initial begin
    rst = 1; stallD = 0; flushD = 0; upd_valid = 0; upd_pred = 0; upd_taken = 0;
    pcF = 0; upd_pc = 0; upd_idx = 0;
    step();
    pcF = 32'h00400010; upd_valid = 1; upd_pred = 1; upd_taken = 0; upd_idx = 10'h004;
    stallD = 1; flushD = 1;
    chk(0, 2, 1, "mispredict_during_rst");
    chk(0, 8, 1, "l_mispredict_during_rst");
    chk(1, 0, 0, "rst_take"); chk(1, 1, 0, "rst_idx");
    chk(1, 3, 0, "rst_lookups"); chk(1, 4, 0, "rst_mispred");
    chk(1, 5, 0, "rst_l_take"); chk(1, 6, 0, "rst_l_idx");
    step();
    rst = 0; upd_valid = 0; stallD = 0; flushD = 0;
    chk(0, 2, 0, "idle_no_mispredict");
    chk(1, 0, 0, "first_lookup_take"); chk(1, 1, 10'h004, "first_lookup_idx");
    chk(1, 3, 1, "lookups_1"); chk(1, 4, 0, "mispred_still_0");
    step();
    upd_valid = 1; upd_idx = 10'h004; upd_taken = 1; upd_pred = 0;
    chk(0, 2, 1, "mispredict_taken");
    chk(1, 1, 10'h004, "no_bypass_idx"); chk(1, 0, 0, "no_bypass_take");
    chk(1, 4, 1, "mispred_0_to_1"); chk(1, 3, 2, "lookups_2");
    step();
    upd_pred = 1;
    chk(0, 2, 0, "correct_pred_no_mispredict");
    chk(1, 1, 10'h005, "ghr1_idx"); chk(1, 4, 1, "mispred_holds");
    step();
    upd_valid = 0;
    chk(1, 1, 10'h007, "ghr3_idx"); chk(1, 0, 0, "ghr3_take");
    step();
    pcF = 32'h0040001C;
    chk(1, 0, 1, "strong_taken_take"); chk(1, 1, 10'h004, "strong_taken_idx");
    chk(1, 3, 5, "lookups_5");
    for (int i = 0; i < 5; i++) begin
      step();
      stallD = 1; upd_valid = 1; upd_idx = 10'h004; upd_taken = 0; upd_pred = 1;
      pcF = 32'h00400100 + 32'(i * 4);
      chk(0, 2, 1, "mispredict_not_taken");
      chk(1, 0, 1, "stall_hold_take"); chk(1, 1, 10'h004, "stall_hold_idx");
      chk(1, 3, 5, "stall_no_lookup"); chk(1, 4, 32'(2 + i), "mispred_count");
    end
    step();
    stallD = 0; upd_valid = 0; pcF = 32'h00400190;
    chk(1, 0, 0, "sat_00_take"); chk(1, 1, 10'h004, "sat_00_idx"); chk(1, 3, 6, "lookups_6");
    step();
    stallD = 1; flushD = 1; pcF = 32'h0040001C;
    chk(1, 0, 0, "flush_over_stall_take"); chk(1, 1, 0, "flush_over_stall_idx");
    chk(1, 3, 6, "flush_no_lookup");
    step();
    rst = 1; stallD = 0; flushD = 0;
    chk(1, 5, 0, "rst2_l_take"); chk(1, 6, 0, "rst2_l_idx");
    chk(1, 3, 0, "rst2_lookups"); chk(1, 4, 0, "rst2_mispred");
    for (int i = 0; i < 4; i++) begin
      step();
      rst = 0; stallD = 1; upd_valid = 1; upd_pc = 32'h00400020; upd_idx = 10'h3FF;
      upd_taken = (i % 2 == 1); upd_pred = upd_taken;
      chk(0, 2, 0, "hist_seq_no_mispredict");
    end
    step();
    stallD = 0; pcF = 32'h00400020; upd_taken = 0; upd_pred = 0;
    chk(1, 6, 10'h00D, "local_mid_idx"); chk(1, 1, 10'h00D, "global_mid_idx");
    step();
    rst = 1; upd_valid = 1; upd_taken = 1; upd_pred = 0;
    chk(0, 2, 1, "mispredict_follows_in_rst");
    chk(1, 5, 0, "rst_mid_l_take"); chk(1, 6, 0, "rst_mid_l_idx");
    chk(1, 7, 0, "rst_mid_l_lookups"); chk(1, 4, 0, "rst_mid_mispred");
    step();
    rst = 0; upd_valid = 0;
    chk(1, 6, 10'h008, "post_rst_local_idx"); chk(1, 1, 10'h008, "post_rst_global_idx");
    chk(1, 7, 1, "post_rst_l_lookups");
    for (int i = 0; i < 8; i++) begin
      step();
      stallD = 1; upd_valid = 1; upd_taken = (i % 2 == 1); upd_pred = upd_taken;
    end
    step();
    upd_valid = 0; stallD = 0;
    chk(1, 6, 10'h05D, "local_55_idx"); chk(1, 5, 0, "local_55_take");
    chk(1, 1, 10'h05D, "global_55_idx"); chk(1, 7, 2, "l_lookups_2");
    step();
    upd_valid = 1; upd_pc = 32'h00400040; upd_taken = 1; upd_pred = 1; stallD = 1;
    step();
    upd_valid = 0; stallD = 0;
    chk(1, 6, 10'h05D, "local_other_pc_idx"); chk(1, 1, 10'h0A3, "global_other_pc_idx");
    step();
    repeat (3) @(posedge clk);
    #6;
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
